hsv_centroid_tracker: RTL and testbench

Inverse of the per-coordinate HSV sampler. Instead of reading the HSV value at a chosen xy, it scans every active pixel of a frame, classifies each one against an HSV threshold window, and outputs the xy centroid of the matching pixels. It sits after the RGB→HSV conversion and feeds paddle and ball position to the AirPong game logic once per frame, during vertical blanking.

---
 rtl/airpong_pkg.sv | 22 ++
 rtl/serial_divider.sv | 69 ++++++
 rtl/hsv_centroid_tracker.sv | 178 +++++++++++++++++
 tb/tb_hsv_centroid_tracker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/airpong_pkg.sv
// Shared AirPong definitions: raster geometry, HSV field layout and tracker states.
package airpong_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;

    // Bit positions of the three channels inside a packed {h, s, v} pixel.
    localparam int HSV_H_MSB = 23;
    localparam int HSV_H_LSB = 16;
    localparam int HSV_S_MSB = 15;
    localparam int HSV_S_LSB = 8;
    localparam int HSV_V_MSB = 7;
    localparam int HSV_V_LSB = 0;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DIV_X = 2'd1,
        DIV_Y = 2'd2,
        DONE  = 2'd3
    } tracker_state_e;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. done pulses exactly
// DIVIDEND_W+1 cycles after start; a zero divisor yields an all-ones quotient.
module serial_divider #(
    parameter int DIVIDEND_W = 30,
    parameter int DIVISOR_W  = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  done
);

    localparam int STEP_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [STEP_W-1:0]     steps_q;
    logic                  run_q;
    logic                  done_q;

    logic [DIVISOR_W:0]    rem_shift_d;
    logic [DIVISOR_W-1:0]  rem_sub_d;
    logic                  take_d;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        rem_shift_d = {rem_q, quo_q[DIVIDEND_W-1]};
        take_d      = (rem_shift_d >= {1'b0, dvs_q});
        // The true difference is below the divisor, so modular truncation is exact.
        rem_sub_d   = rem_shift_d[DIVISOR_W-1:0] - dvs_q;
    end

    // Iteration control: load on start, then one restoring step per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            steps_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                quo_q   <= dividend;
                rem_q   <= '0;
                dvs_q   <= divisor;
                steps_q <= STEP_W'(DIVIDEND_W);
                run_q   <= 1'b1;
            end else if (run_q) begin
                quo_q   <= {quo_q[DIVIDEND_W-2:0], take_d};
                rem_q   <= take_d ? rem_sub_d : rem_shift_d[DIVISOR_W-1:0];
                steps_q <= steps_q - STEP_W'(1);
                if (steps_q == STEP_W'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/hsv_centroid_tracker.sv
// Classifies every active pixel against an HSV window and reports the centroid
// of the matching pixels once per frame, computed during vertical blanking.
module hsv_centroid_tracker #(
    parameter int H_ACTIVE   = airpong_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = airpong_pkg::V_ACTIVE,
    parameter int MIN_PIXELS = 16,
    parameter int CNT_W      = 20,
    parameter int SUM_W      = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      hcount,
    input  logic [9:0]       vcount,
    input  logic [23:0]      hsv,
    input  logic             enable,
    input  logic [7:0]       h_min,
    input  logic [7:0]       h_max,
    input  logic [7:0]       s_min,
    input  logic [7:0]       v_min,
    output logic [10:0]      x_centroid,
    output logic [9:0]       y_centroid,
    output logic [CNT_W-1:0] pixel_count,
    output logic             found,
    output logic             frame_done,
    output logic             busy
);

    import airpong_pkg::*;

    localparam logic [10:0]      H_LIM   = 11'(H_ACTIVE);
    localparam logic [9:0]       V_LIM   = 10'(V_ACTIVE);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    logic [7:0] pix_h, pix_s, pix_v;
    logic       hue_ok, pix_match, active, accum_en, frame_end;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;

    tracker_state_e   state_q;
    logic [CNT_W-1:0] cnt_hold_q;
    logic [SUM_W-1:0] sum_x_hold_q, sum_y_hold_q;
    logic [10:0]      x_quot_q, x_centroid_q;
    logic [9:0]       y_centroid_q;
    logic [CNT_W-1:0] pixel_count_q;
    logic             found_q, frame_done_q, start_x_q;

    logic             div_start, div_done;
    logic [SUM_W-1:0] div_dividend, div_quotient;
    logic             unused_quot_hi;

    // Pixel classification; the hue window wraps through red when h_min > h_max.
    always_comb begin
        pix_h     = hsv[HSV_H_MSB:HSV_H_LSB];
        pix_s     = hsv[HSV_S_MSB:HSV_S_LSB];
        pix_v     = hsv[HSV_V_MSB:HSV_V_LSB];
        hue_ok    = (h_min <= h_max) ? ((pix_h >= h_min) && (pix_h <= h_max))
                                     : ((pix_h >= h_min) || (pix_h <= h_max));
        pix_match = hue_ok && (pix_s >= s_min) && (pix_v >= v_min);
        active    = (hcount < H_LIM) && (vcount < V_LIM);
        accum_en  = enable && active && pix_match;
        frame_end = (hcount == 11'd0) && (vcount == V_LIM);
    end

    // Accumulator next state: frame end always clears, even if the frame is dropped.
    always_comb begin
        cnt_d   = cnt_q;
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        if (frame_end) begin
            cnt_d   = '0;
            sum_x_d = '0;
            sum_y_d = '0;
        end else if (accum_en) begin
            cnt_d   = cnt_q + CNT_W'(1);
            sum_x_d = sum_x_q + SUM_W'(hcount);
            sum_y_d = sum_y_q + SUM_W'(vcount);
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
        end
    end

    // Frame FSM; results are registered on the edge entering DONE so frame_done
    // is high for exactly the single DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ACCUM;
            cnt_hold_q    <= '0;
            sum_x_hold_q  <= '0;
            sum_y_hold_q  <= '0;
            x_quot_q      <= '0;
            x_centroid_q  <= '0;
            y_centroid_q  <= '0;
            pixel_count_q <= '0;
            found_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            start_x_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            start_x_q    <= 1'b0;
            case (state_q)
                ACCUM: begin
                    if (frame_end) begin
                        cnt_hold_q   <= cnt_q;
                        sum_x_hold_q <= sum_x_q;
                        sum_y_hold_q <= sum_y_q;
                        if ((cnt_q >= MIN_CNT) && (cnt_q != '0)) begin
                            state_q   <= DIV_X;
                            start_x_q <= 1'b1;
                        end else begin
                            state_q       <= DONE;
                            pixel_count_q <= cnt_q;
                            found_q       <= 1'b0;
                            frame_done_q  <= 1'b1;
                        end
                    end
                end
                DIV_X: begin
                    if (div_done) begin
                        x_quot_q <= div_quotient[10:0];
                        state_q  <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    if (div_done) begin
                        x_centroid_q  <= x_quot_q;
                        y_centroid_q  <= div_quotient[9:0];
                        pixel_count_q <= cnt_hold_q;
                        found_q       <= 1'b1;
                        frame_done_q  <= 1'b1;
                        state_q       <= DONE;
                    end
                end
                DONE:    state_q <= ACCUM;
                default: state_q <= ACCUM;
            endcase
        end
    end

    // The y division is launched in the same cycle the x result arrives.
    assign div_start    = start_x_q || ((state_q == DIV_X) && div_done);
    assign div_dividend = start_x_q ? sum_x_hold_q : sum_y_hold_q;

    serial_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (cnt_hold_q),
        .quotient (div_quotient),
        .done     (div_done)
    );

    // Centroids always fit the raster, so the upper quotient bits are zero.
    assign unused_quot_hi = ^div_quotient[SUM_W-1:11];

    assign x_centroid  = x_centroid_q;
    assign y_centroid  = y_centroid_q;
    assign pixel_count = pixel_count_q;
    assign found       = found_q;
    assign frame_done  = frame_done_q;
    assign busy        = (state_q == DIV_X) || (state_q == DIV_Y);

endmodule

// File: tb/tb_hsv_centroid_tracker.sv
// Bench for hsv_centroid_tracker: one full-size instance (MIN_PIXELS=1) and one
// small-raster instance (64x48, MIN_PIXELS=16) with independent pixel buses.
module tb_hsv_centroid_tracker;

    localparam int HA = 1024, VA = 768;
    localparam int HB = 64,   VB = 48;

    logic clk = 1'b0;
    logic reset;
    logic [10:0] hc_a, hc_b;
    logic [9:0]  vc_a, vc_b;
    logic [23:0] hsv_a, hsv_b;
    logic        en_a, en_b;
    logic [7:0]  th_hmin, th_hmax, th_smin, th_vmin;

    logic [10:0] x_a, x_b;
    logic [9:0]  y_a, y_b;
    logic [19:0] pc_a, pc_b;
    logic        fnd_a, fnd_b, fd_a, fd_b, bsy_a, bsy_b;

    int errors = 0;
    int checks = 0;
    int exp_x[2];
    int exp_y[2];

    typedef struct { int x; int y; logic [23:0] hsv; } pix_t;
    pix_t pix_q[$];

    typedef struct { int h; int s; int v; int hmin; int hmax; int smin; int vmin; int exp_match; } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    hsv_centroid_tracker #(.MIN_PIXELS(1)) dut_a (
        .clk(clk), .reset(reset), .hcount(hc_a), .vcount(vc_a), .hsv(hsv_a),
        .enable(en_a), .h_min(th_hmin), .h_max(th_hmax), .s_min(th_smin), .v_min(th_vmin),
        .x_centroid(x_a), .y_centroid(y_a), .pixel_count(pc_a), .found(fnd_a),
        .frame_done(fd_a), .busy(bsy_a)
    );

    hsv_centroid_tracker #(.H_ACTIVE(HB), .V_ACTIVE(VB), .MIN_PIXELS(16)) dut_b (
        .clk(clk), .reset(reset), .hcount(hc_b), .vcount(vc_b), .hsv(hsv_b),
        .enable(en_b), .h_min(th_hmin), .h_max(th_hmax), .s_min(th_smin), .v_min(th_vmin),
        .x_centroid(x_b), .y_centroid(y_b), .pixel_count(pc_b), .found(fnd_b),
        .frame_done(fd_b), .busy(bsy_b)
    );

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference classification straight from the window rules.
    function automatic bit ref_match(input logic [23:0] p);
        int h, s, v, lo, hi;
        bit hue;
        h = int'(p[23:16]); s = int'(p[15:8]); v = int'(p[7:0]);
        lo = int'(th_hmin); hi = int'(th_hmax);
        if (lo <= hi) hue = (h >= lo) && (h <= hi);
        else          hue = (h >= lo) || (h <= hi);
        return hue && (s >= int'(th_smin)) && (v >= int'(th_vmin));
    endfunction

    task automatic set_in(input int w, input int x, input int y, input logic [23:0] p);
        if (w == 0) begin hc_a = 11'(x); vc_a = 10'(y); hsv_a = p; end
        else        begin hc_b = 11'(x); vc_b = 10'(y); hsv_b = p; end
    endtask

    task automatic set_idle();
        set_in(0, HA, 0, 24'h0);
        set_in(1, HB, 0, 24'h0);
    endtask

    function automatic logic g_done(input int w); return (w == 0) ? fd_a : fd_b; endfunction
    function automatic logic g_busy(input int w); return (w == 0) ? bsy_a : bsy_b; endfunction

    task automatic set_th(input int hmin, input int hmax, input int smin, input int vmin);
        th_hmin = 8'(hmin); th_hmax = 8'(hmax); th_smin = 8'(smin); th_vmin = 8'(vmin);
    endtask

    // Drives pix_q and a frame-end strobe into one instance and checks the result.
    task automatic run_frame(input int w, input bit en, input string tag);
        int hlim, vlim, minp, exp_lat, lat;
        longint cnt, sx, sy;
        hlim = (w == 0) ? HA : HB;
        vlim = (w == 0) ? VA : VB;
        minp = (w == 0) ? 1 : 16;
        cnt = 0; sx = 0; sy = 0;
        foreach (pix_q[i]) begin
            if (en && pix_q[i].x < hlim && pix_q[i].y < vlim && ref_match(pix_q[i].hsv)) begin
                cnt++; sx += pix_q[i].x; sy += pix_q[i].y;
            end
        end
        exp_lat = (cnt >= minp && cnt != 0) ? 64 : 1;
        if (exp_lat == 64) begin
            exp_x[w] = int'(sx / cnt);
            exp_y[w] = int'(sy / cnt);
        end
        if (w == 0) en_a = en; else en_b = en;
        foreach (pix_q[i]) begin
            set_in(w, pix_q[i].x, pix_q[i].y, pix_q[i].hsv);
            @(negedge clk);
        end
        set_in(w, 0, vlim, 24'h0);
        @(negedge clk);
        set_idle();
        chk({tag, "_busy_start"}, g_busy(w), (exp_lat == 64) ? 1 : 0);
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            if (g_done(w)) begin lat = n; break; end
            @(negedge clk);
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_count"}, (w == 0) ? pc_a : pc_b, cnt);
        chk({tag, "_found"}, (w == 0) ? fnd_a : fnd_b, (exp_lat == 64) ? 1 : 0);
        chk({tag, "_x"}, (w == 0) ? x_a : x_b, exp_x[w]);
        chk({tag, "_y"}, (w == 0) ? y_a : y_b, exp_y[w]);
        $display("frame %s dut=%0d count=%0d x=%0d y=%0d found=%0d latency=%0d", tag, w,
                 (w == 0) ? pc_a : pc_b, (w == 0) ? x_a : x_b, (w == 0) ? y_a : y_b,
                 (w == 0) ? fnd_a : fnd_b, lat);
        @(negedge clk);
        chk({tag, "_pulse_end"}, g_done(w), 0);
        chk({tag, "_busy_end"}, g_busy(w), 0);
    endtask

    initial begin
        int seen;
        exp_x[0] = 0; exp_x[1] = 0; exp_y[0] = 0; exp_y[1] = 0;
        reset = 1'b1;
        en_a = 1'b1; en_b = 1'b1;
        set_idle();
        set_th(120, 140, 8'h40, 8'h40);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state of both instances.
        chk("rst_x_a", x_a, 0);   chk("rst_y_a", y_a, 0);
        chk("rst_cnt_a", pc_a, 0); chk("rst_found_a", fnd_a, 0);
        chk("rst_done_a", fd_a, 0); chk("rst_busy_a", bsy_a, 0);
        chk("rst_cnt_b", pc_b, 0); chk("rst_done_b", fd_b, 0);

        // Classification table: one pixel at (100,50) per frame.
        vecs[0] = '{130, 8'hC0, 8'hC0, 120, 140, 8'h40, 8'h40, 1};
        vecs[1] = '{119, 8'hC0, 8'hC0, 120, 140, 8'h40, 8'h40, 0};
        vecs[2] = '{140, 8'hC0, 8'hC0, 120, 140, 8'h40, 8'h40, 1};
        vecs[3] = '{141, 8'hC0, 8'hC0, 120, 140, 8'h40, 8'h40, 0};
        vecs[4] = '{250, 8'hC0, 8'hC0, 240, 10,  8'h40, 8'h40, 1};
        vecs[5] = '{5,   8'hC0, 8'hC0, 240, 10,  8'h40, 8'h40, 1};
        vecs[6] = '{20,  8'hC0, 8'hC0, 240, 10,  8'h40, 8'h40, 0};
        vecs[7] = '{130, 8'h3F, 8'hC0, 120, 140, 8'h40, 8'h40, 0};
        vecs[8] = '{130, 8'hC0, 8'h40, 120, 140, 8'h40, 8'h40, 1};
        vecs[9] = '{77,  8'hC0, 8'hC0, 77,  77,  8'h40, 8'h40, 1};
        for (int i = 0; i < 10; i++) begin
            set_th(vecs[i].hmin, vecs[i].hmax, vecs[i].smin, vecs[i].vmin);
            pix_q.delete();
            pix_q.push_back('{100, 50, {8'(vecs[i].h), 8'(vecs[i].s), 8'(vecs[i].v)}});
            run_frame(0, 1'b1, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_match", i), pc_a, vecs[i].exp_match);
        end

        // 10x10 block.
        set_th(120, 140, 8'h40, 8'h40);
        pix_q.delete();
        for (int y = 300; y < 310; y++)
            for (int x = 200; x < 210; x++) pix_q.push_back('{x, y, 24'h80C0C0});
        run_frame(0, 1'b1, "block");
        chk("block_cnt_const", pc_a, 100); chk("block_x_const", x_a, 204); chk("block_y_const", y_a, 304);

        // Hue wrap-around, one rejected pixel.
        set_th(240, 10, 8'h40, 8'h40);
        pix_q.delete();
        pix_q.push_back('{10, 10, 24'hFAC0C0});
        pix_q.push_back('{30, 10, 24'h05C0C0});
        pix_q.push_back('{500, 500, 24'h14C0C0});
        run_frame(0, 1'b1, "wrap");
        chk("wrap_cnt_const", pc_a, 2); chk("wrap_x_const", x_a, 20); chk("wrap_y_const", y_a, 10);

        // Disabled frame: count 0, centroid holds.
        pix_q.delete();
        pix_q.push_back('{40, 40, 24'hFAC0C0});
        run_frame(0, 1'b0, "disabled");
        chk("disabled_x_hold", x_a, 20);
        en_a = 1'b1;

        // Whole small raster matches, plus matching pixels in blanking.
        set_th(120, 140, 8'h40, 8'h40);
        pix_q.delete();
        for (int y = 0; y < VB; y++)
            for (int x = 0; x < HB; x++) pix_q.push_back('{x, y, 24'h80C0C0});
        pix_q.push_back('{HB, 5, 24'h80C0C0});
        pix_q.push_back('{3, VB + 1, 24'h80C0C0});
        run_frame(1, 1'b1, "full");
        chk("full_cnt_const", pc_b, HB * VB); chk("full_x_const", x_b, 31); chk("full_y_const", y_b, 23);

        // Below threshold: 8 pixels against MIN_PIXELS=16.
        pix_q.delete();
        for (int x = 5; x < 13; x++) pix_q.push_back('{x, 5, 24'h80C0C0});
        run_frame(1, 1'b1, "below");
        chk("below_cnt_const", pc_b, 8); chk("below_x_hold", x_b, 31);

        // Randomized frames against the reference model.
        for (int r = 0; r < 8; r++) begin
            int w, hl, vl, n, x, y;
            w = r % 2;
            hl = (w == 0) ? HA : HB;
            vl = (w == 0) ? VA : VB;
            n = (w == 0) ? 20 : 60;
            set_th($urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 128), $urandom_range(0, 128));
            pix_q.delete();
            for (int k = 0; k < n; k++) begin
                x = $urandom_range(0, hl + 10);
                y = $urandom_range(0, vl + 4);
                if (x == 0 && y == vl) x = 1;
                pix_q.push_back('{x, y, 24'($urandom)});
            end
            run_frame(w, ($urandom_range(0, 9) != 0), $sformatf("rand%0d", r));
        end

        // Reset 20 cycles into DIV_X aborts the division silently.
        set_th(120, 140, 8'h40, 8'h40);
        en_a = 1'b1;
        pix_q.delete();
        pix_q.push_back('{100, 50, 24'h80C0C0});
        foreach (pix_q[i]) begin
            set_in(0, pix_q[i].x, pix_q[i].y, pix_q[i].hsv);
            @(negedge clk);
        end
        set_in(0, 0, VA, 24'h0);
        @(negedge clk);
        set_idle();
        repeat (20) @(negedge clk);
        chk("abort_busy", bsy_a, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_x[0] = 0; exp_y[0] = 0; exp_x[1] = 0; exp_y[1] = 0;
        chk("abort_x", x_a, 0); chk("abort_y", y_a, 0); chk("abort_cnt", pc_a, 0);
        chk("abort_found", fnd_a, 0); chk("abort_busy_off", bsy_a, 0);
        seen = 0;
        repeat (100) begin
            if (fd_a) seen = 1;
            @(negedge clk);
        end
        chk("abort_no_done", seen, 0);
        pix_q.delete();
        pix_q.push_back('{7, 3, 24'h80C0C0});
        run_frame(0, 1'b1, "after_abort");
        chk("after_abort_x_const", x_a, 7); chk("after_abort_y_const", y_a, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
